// File: rtl/bcedn_pool_index_writer_if.sv
// Stream-in / pooled-out / index-SRAM-write bundle for the encoder 2x2 max-pool stage.
// The interface widths track the same frame geometry the pool block is built for.
interface bcedn_pool_index_writer_if #(
    parameter int H_IN = 64,
    parameter int W_IN = 256,
    parameter int D    = 512,
    parameter int N_PE = 1
);
    localparam int WORDS  = D / N_PE;
    localparam int NPOOL  = (H_IN / 2) * (W_IN / 2);
    localparam int ADDR_W = ($clog2(NPOOL * WORDS) < 1) ? 1 : $clog2(NPOOL * WORDS);
    localparam int WD_W   = 2 * N_PE;

    logic              start;
    logic              in_en;
    logic              in_rdy;
    logic [D-1:0]      data_in;
    logic              out_en;
    logic [D-1:0]      data_out;
    logic              pindex_wr;
    logic [ADDR_W-1:0] pindex_wr_addr;
    logic [WD_W-1:0]   pindex_wr_data;
    logic              done;

    modport master (
        output start, in_en, data_in,
        input  in_rdy, out_en, data_out, pindex_wr, pindex_wr_addr, pindex_wr_data, done
    );

    modport slave (
        input  start, in_en, data_in,
        output in_rdy, out_en, data_out, pindex_wr, pindex_wr_addr, pindex_wr_data, done
    );
endinterface

// File: rtl/bcedn_pool_index_writer.sv
// Encoder 2x2 binary max-pool: emits pooled pixels and writes per-channel argmax
// indices into index SRAM in exactly the word/address order the decoder unpooling reads.
module bcedn_pool_index_writer #(
    parameter int H_IN = 64,
    parameter int W_IN = 256,
    parameter int D    = 512,
    parameter int N_PE = 1
) (
    input  logic clk,
    input  logic rst,
    bcedn_pool_index_writer_if.slave bus
);
    localparam int PINDEX_WIDTH     = 2;
    localparam int WORDS            = D / N_PE;
    localparam int NPOOL            = (H_IN / 2) * (W_IN / 2);
    localparam int INDEX_ADDR_WIDTH = ($clog2(NPOOL * WORDS) < 1) ? 1 : $clog2(NPOOL * WORDS);
    localparam int COL_W            = $clog2(W_IN);
    localparam int P_W              = ($clog2(NPOOL) < 1) ? 1 : $clog2(NPOOL);
    localparam int K_W              = $clog2(WORDS + 1);
    localparam int WD_W             = PINDEX_WIDTH * N_PE;

    typedef enum logic [1:0] {S_IDLE, S_ROW_EVEN, S_ROW_ODD, S_WRITE} state_t;

    state_t                      r_state;
    logic [COL_W-1:0]            r_col;
    logic [P_W-1:0]              r_pooled;
    logic [K_W-1:0]              r_k;
    logic                        r_in_rdy;
    logic                        r_out_en;
    logic [D-1:0]                r_data_out;
    logic                        r_wr;
    logic [INDEX_ADDR_WIDTH-1:0] r_wr_addr;
    logic [WD_W-1:0]             r_wr_data;
    logic                        r_done;
    logic [D-1:0]                r_buf [W_IN];
    logic [D-1:0]                r_bl;
    logic [2*D-1:0]              r_idx;

    logic                        w_beat;
    logic                        w_col_last;
    logic                        w_win_done;
    logic                        w_pool_last;
    logic [D-1:0]                w_tl;
    logic [D-1:0]                w_tr;
    logic [D-1:0]                w_pool;
    logic [2*D-1:0]              w_idx;
    logic [WD_W-1:0]             w_word0;
    logic [WD_W-1:0]             w_word_k;
    logic [INDEX_ADDR_WIDTH-1:0] w_base_addr;

    // Per-channel argmax with TL > TR > BL > BR priority; an all-zero window reports TL.
    // Channel c lives at bit D-1-c, so its index lands in bits [2(D-1-c) +: 2].
    function automatic logic [2*D-1:0] pool_index(input logic [D-1:0] tl, input logic [D-1:0] tr,
                                                   input logic [D-1:0] bl, input logic [D-1:0] br);
        logic [2*D-1:0] idx;
        idx = '0;
        for (int b = 0; b < D; b++) begin
            if (tl[b])      idx[2*b +: 2] = 2'd0;
            else if (tr[b]) idx[2*b +: 2] = 2'd1;
            else if (bl[b]) idx[2*b +: 2] = 2'd2;
            else if (br[b]) idx[2*b +: 2] = 2'd3;
            else            idx[2*b +: 2] = 2'd0;
        end
        return idx;
    endfunction

    assign w_beat      = bus.in_en && r_in_rdy;
    assign w_col_last  = (r_col == COL_W'(W_IN - 1));
    assign w_win_done  = (r_state == S_ROW_ODD) && w_beat && r_col[0];
    assign w_pool_last = (r_pooled == P_W'(NPOOL - 1));
    assign w_tl        = r_buf[r_col - COL_W'(1)];
    assign w_tr        = r_buf[r_col];
    assign w_pool      = w_tl | w_tr | r_bl | bus.data_in;
    assign w_idx       = pool_index(w_tl, w_tr, r_bl, bus.data_in);
    assign w_word0     = w_idx[2*D-1 -: WD_W];
    // Word k sits k slots below the top; past the last word the shift just yields zero.
    assign w_word_k    = WD_W'(r_idx >> ((WORDS - 1 - int'(r_k)) * WD_W));
    assign w_base_addr = INDEX_ADDR_WIDTH'(r_pooled) * INDEX_ADDR_WIDTH'(WORDS);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_col      <= '0;
            r_pooled   <= '0;
            r_k        <= '0;
            r_in_rdy   <= 1'b0;
            r_out_en   <= 1'b0;
            r_data_out <= '0;
            r_wr       <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_done     <= 1'b0;
        end else begin
            r_out_en <= 1'b0;
            r_done   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state  <= S_ROW_EVEN;
                        r_in_rdy <= 1'b1;
                        r_col    <= '0;
                        r_pooled <= '0;
                        r_k      <= '0;
                    end
                end
                S_ROW_EVEN: begin
                    if (w_beat) begin
                        if (w_col_last) begin
                            r_col   <= '0;
                            r_state <= S_ROW_ODD;
                        end else begin
                            r_col <= r_col + COL_W'(1);
                        end
                    end
                end
                S_ROW_ODD: begin
                    if (w_beat) begin
                        r_col <= w_col_last ? '0 : r_col + COL_W'(1);
                    end
                    if (w_win_done) begin
                        r_state    <= S_WRITE;
                        r_in_rdy   <= 1'b0;
                        r_out_en   <= 1'b1;
                        r_data_out <= w_pool;
                        r_wr       <= 1'b1;
                        r_wr_addr  <= w_base_addr;
                        r_wr_data  <= w_word0;
                        r_k        <= K_W'(1);
                    end
                end
                S_WRITE: begin
                    if (r_k < K_W'(WORDS)) begin
                        r_wr_addr <= r_wr_addr + INDEX_ADDR_WIDTH'(1);
                        r_wr_data <= w_word_k;
                        r_k       <= r_k + K_W'(1);
                    end else begin
                        r_wr <= 1'b0;
                        r_k  <= '0;
                        if (w_pool_last) begin
                            r_state  <= S_IDLE;
                            r_pooled <= '0;
                            r_done   <= 1'b1;
                        end else begin
                            r_pooled <= r_pooled + P_W'(1);
                            r_in_rdy <= 1'b1;
                            r_state  <= (r_col == '0) ? S_ROW_EVEN : S_ROW_ODD;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Row buffer, bottom-left latch and index snapshot are pure datapath storage.
    always_ff @(posedge clk) begin
        if ((r_state == S_ROW_EVEN) && w_beat) r_buf[r_col] <= bus.data_in;
        if ((r_state == S_ROW_ODD) && w_beat && !r_col[0]) r_bl <= bus.data_in;
        if (w_win_done) r_idx <= w_idx;
    end

    assign bus.in_rdy         = r_in_rdy;
    assign bus.out_en         = r_out_en;
    assign bus.data_out       = r_data_out;
    assign bus.pindex_wr      = r_wr;
    assign bus.pindex_wr_addr = r_wr_addr;
    assign bus.pindex_wr_data = r_wr_data;
    assign bus.done           = r_done;
endmodule

// File: tb/tb_bcedn_pool_index_writer.sv
// Bench for the 2x2 pool/index writer on a 4x4x4 frame with two indices per SRAM word.
module tb_bcedn_pool_index_writer;
    localparam int H = 4, W = 4, D = 4, NPE = 2;
    localparam int WORDS = D / NPE;
    localparam int NP = (H / 2) * (W / 2);
    localparam int NW = NP * WORDS;
    localparam int NBEAT = H * W;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bcedn_pool_index_writer_if #(.H_IN(H), .W_IN(W), .D(D), .N_PE(NPE)) u_if ();

    bcedn_pool_index_writer #(.H_IN(H), .W_IN(W), .D(D), .N_PE(NPE)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    logic [D-1:0] pix [NBEAT];
    logic [D-1:0] exp_out [NP];
    logic [3:0]   exp_wd [NW];

    logic [D-1:0] q_out [$];
    logic [2:0]   q_wa [$];
    logic [3:0]   q_wd [$];
    int           q_wcyc [$];
    int           br_cyc [$];
    int           n_done = 0;
    int           done_cyc = 0;

    always @(negedge clk) begin
        if (u_if.out_en) q_out.push_back(u_if.data_out);
        if (u_if.pindex_wr) begin
            q_wa.push_back(u_if.pindex_wr_addr);
            q_wd.push_back(u_if.pindex_wr_data);
            q_wcyc.push_back(cyc);
        end
        if (u_if.done) begin
            n_done++;
            done_cyc = cyc;
        end
    end

    // Reference: look at each 2x2 window of the raster frame directly.
    function automatic void build_model();
        logic [D-1:0] tl, tr, bl, br;
        logic [1:0]   id;
        int           b, a, s;
        for (int j = 0; j < NW; j++) exp_wd[j] = '0;
        for (int p = 0; p < NP; p++) begin
            tl = pix[(2 * (p / (W / 2))) * W + 2 * (p % (W / 2))];
            tr = pix[(2 * (p / (W / 2))) * W + 2 * (p % (W / 2)) + 1];
            bl = pix[(2 * (p / (W / 2)) + 1) * W + 2 * (p % (W / 2))];
            br = pix[(2 * (p / (W / 2)) + 1) * W + 2 * (p % (W / 2)) + 1];
            exp_out[p] = tl | tr | bl | br;
            for (int c = 0; c < D; c++) begin
                b = D - 1 - c;
                if (tl[b]) id = 2'd0;
                else if (tr[b]) id = 2'd1;
                else if (bl[b]) id = 2'd2;
                else if (br[b]) id = 2'd3;
                else id = 2'd0;
                a = p * WORDS + c / NPE;
                s = (NPE - 1 - c % NPE) * 2;
                exp_wd[a][s +: 2] = id;
            end
        end
    endfunction

    task automatic begin_frame();
        @(negedge clk);
        u_if.start = 1'b1;
    endtask

    task automatic drive_frame(input int gap_pct, input bit chain, input bit mid_start,
                               input int abort_at, input bit chk_rdy);
        int i, guard, lowcnt;
        bit tracking, xfer;
        i = 0; guard = 0; lowcnt = 0; tracking = 0;
        while (i < NBEAT && guard < 4000) begin
            @(negedge clk);
            guard++;
            u_if.start = mid_start && (i >= 6) && (i <= 7);
            if (chk_rdy && tracking) begin
                if (u_if.in_rdy) begin
                    total++;
                    if (lowcnt != WORDS) begin
                        bad++;
                        $display("FAIL rdy_low_run: got %0d cycles required %0d", lowcnt, WORDS);
                    end
                    tracking = 0;
                end else begin
                    lowcnt++;
                end
            end
            u_if.in_en   = (gap_pct == 0) ? 1'b1 : ($urandom_range(99) >= gap_pct);
            u_if.data_in = pix[i];
            xfer = u_if.in_en && u_if.in_rdy;
            if (xfer) begin
                if (((i / W) % 2 == 1) && (i % 2 == 1)) begin
                    br_cyc.push_back(cyc);
                    if (i != NBEAT - 1) begin
                        tracking = 1;
                        lowcnt = 0;
                    end
                end
                if (i == abort_at) i = NBEAT;
                else i++;
            end
        end
        total++;
        if (guard >= 4000) begin
            bad++;
            $display("FAIL beat_timeout: got %0d beats required %0d", i, NBEAT);
        end
        if (abort_at < 0) begin
            guard = 0;
            do begin
                @(negedge clk);
                guard++;
            end while (!u_if.done && guard < 100);
            total++;
            if (!u_if.done) begin
                bad++;
                $display("FAIL done_timeout: got done=%0b required 1", u_if.done);
            end
            u_if.in_en = 1'b0;
            u_if.start = chain;
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        u_if.start = 1'b0;
        u_if.in_en = 1'b0;
        u_if.data_in = '0;
        repeat (3) @(negedge clk);
        total += 7;
        if (u_if.in_rdy !== 1'b0) begin bad++; $display("FAIL rst_in_rdy: got %b required 0", u_if.in_rdy); end
        if (u_if.out_en !== 1'b0) begin bad++; $display("FAIL rst_out_en: got %b required 0", u_if.out_en); end
        if (u_if.data_out !== 4'h0) begin bad++; $display("FAIL rst_data_out: got %h required 0", u_if.data_out); end
        if (u_if.pindex_wr !== 1'b0) begin bad++; $display("FAIL rst_wr: got %b required 0", u_if.pindex_wr); end
        if (u_if.pindex_wr_addr !== 3'd0) begin bad++; $display("FAIL rst_addr: got %h required 0", u_if.pindex_wr_addr); end
        if (u_if.pindex_wr_data !== 4'h0) begin bad++; $display("FAIL rst_wdata: got %h required 0", u_if.pindex_wr_data); end
        if (u_if.done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b required 0", u_if.done); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (u_if.in_rdy !== 1'b0) begin bad++; $display("FAIL idle_in_rdy: got %b required 0", u_if.in_rdy); end
    endtask

    task automatic test_full_frame();
        int bo, bw, bd;
        pix[0] = 4'b1000; pix[1] = 4'b0100; pix[4] = 4'b0010; pix[5] = 4'b0001;
        pix[2] = 4'h0; pix[3] = 4'h0; pix[6] = 4'h0; pix[7] = 4'h0;
        pix[8] = 4'hF; pix[9] = 4'hF; pix[12] = 4'hF; pix[13] = 4'hF;
        pix[10] = 4'($urandom); pix[11] = 4'($urandom); pix[14] = 4'($urandom); pix[15] = 4'($urandom);
        build_model();
        bo = q_out.size(); bw = q_wa.size(); bd = n_done;
        br_cyc.delete();
        begin_frame();
        drive_frame(0, 1'b0, 1'b0, -1, 1'b1);
        total += 10;
        if (q_out.size() - bo != NP) begin bad++; $display("FAIL ff_out_count: got %0d required %0d", q_out.size() - bo, NP); end
        if (q_wa.size() - bw != NW) begin bad++; $display("FAIL ff_wr_count: got %0d required %0d", q_wa.size() - bw, NW); end
        if (n_done - bd != 1) begin bad++; $display("FAIL ff_done_count: got %0d required 1", n_done - bd); end
        if (q_out[bo] !== 4'b1111) begin bad++; $display("FAIL ff_p0_pool: got %b required 1111", q_out[bo]); end
        if (q_wd[bw] !== 4'b0001) begin bad++; $display("FAIL ff_p0_w0: got %b required 0001", q_wd[bw]); end
        if (q_wd[bw+1] !== 4'b1011) begin bad++; $display("FAIL ff_p0_w1: got %b required 1011", q_wd[bw+1]); end
        if (q_out[bo+1] !== 4'b0000 || q_wd[bw+2] !== 4'b0000 || q_wd[bw+3] !== 4'b0000) begin
            bad++; $display("FAIL ff_zero_win: got %b/%b/%b required 0000/0000/0000", q_out[bo+1], q_wd[bw+2], q_wd[bw+3]);
        end
        if (q_out[bo+2] !== 4'b1111 || q_wd[bw+4] !== 4'b0000 || q_wd[bw+5] !== 4'b0000) begin
            bad++; $display("FAIL ff_ones_win: got %b/%b/%b required 1111/0000/0000", q_out[bo+2], q_wd[bw+4], q_wd[bw+5]);
        end
        if (q_out[bo+3] !== exp_out[3]) begin bad++; $display("FAIL ff_p3_pool: got %b required %b", q_out[bo+3], exp_out[3]); end
        if (done_cyc !== q_wcyc[bw+NW-1] + 1) begin bad++; $display("FAIL ff_done_time: got %0d required %0d", done_cyc, q_wcyc[bw+NW-1] + 1); end
        for (int j = 0; j < NW; j++) begin
            total += 3;
            if (q_wa[bw+j] !== 3'(j)) begin bad++; $display("FAIL ff_addr[%0d]: got %0d required %0d", j, q_wa[bw+j], j); end
            if (q_wd[bw+j] !== exp_wd[j]) begin bad++; $display("FAIL ff_wdata[%0d]: got %b required %b", j, q_wd[bw+j], exp_wd[j]); end
            if (q_wcyc[bw+j] !== br_cyc[j/WORDS] + 1 + j % WORDS) begin
                bad++; $display("FAIL ff_wr_time[%0d]: got %0d required %0d", j, q_wcyc[bw+j], br_cyc[j/WORDS] + 1 + j % WORDS);
            end
        end
    endtask

    task automatic test_back_to_back();
        int bo, bw, bd;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < NBEAT; i++) pix[i] = 4'($urandom);
            build_model();
            bo = q_out.size(); bw = q_wa.size(); bd = n_done;
            if (f == 0) begin_frame();
            drive_frame(35, (f < 2), 1'b0, -1, 1'b0);
            total += 3;
            if (q_out.size() - bo != NP) begin bad++; $display("FAIL b2b%0d_out_count: got %0d required %0d", f, q_out.size() - bo, NP); end
            if (q_wa.size() - bw != NW) begin bad++; $display("FAIL b2b%0d_wr_count: got %0d required %0d", f, q_wa.size() - bw, NW); end
            if (n_done - bd != 1) begin bad++; $display("FAIL b2b%0d_done_count: got %0d required 1", f, n_done - bd); end
            for (int p = 0; p < NP; p++) begin
                total++;
                if (q_out[bo+p] !== exp_out[p]) begin bad++; $display("FAIL b2b%0d_pool[%0d]: got %b required %b", f, p, q_out[bo+p], exp_out[p]); end
            end
            for (int j = 0; j < NW; j++) begin
                total += 2;
                if (q_wa[bw+j] !== 3'(j)) begin bad++; $display("FAIL b2b%0d_addr[%0d]: got %0d required %0d", f, j, q_wa[bw+j], j); end
                if (q_wd[bw+j] !== exp_wd[j]) begin bad++; $display("FAIL b2b%0d_wdata[%0d]: got %b required %b", f, j, q_wd[bw+j], exp_wd[j]); end
            end
        end
    endtask

    task automatic test_reset_mid_write();
        int bo, bw, bd;
        for (int i = 0; i < NBEAT; i++) pix[i] = 4'($urandom);
        begin_frame();
        drive_frame(0, 1'b0, 1'b0, 13, 1'b0);
        @(negedge clk);
        total++;
        if (u_if.pindex_wr !== 1'b1) begin bad++; $display("FAIL mid_in_write: got wr=%b required 1", u_if.pindex_wr); end
        rst = 1'b1;
        u_if.in_en = 1'b0;
        @(negedge clk);
        total += 5;
        if (u_if.in_rdy !== 1'b0) begin bad++; $display("FAIL mid_rst_in_rdy: got %b required 0", u_if.in_rdy); end
        if (u_if.out_en !== 1'b0 || u_if.done !== 1'b0) begin bad++; $display("FAIL mid_rst_pulses: got %b%b required 00", u_if.out_en, u_if.done); end
        if (u_if.data_out !== 4'h0) begin bad++; $display("FAIL mid_rst_data_out: got %h required 0", u_if.data_out); end
        if (u_if.pindex_wr !== 1'b0) begin bad++; $display("FAIL mid_rst_wr: got %b required 0", u_if.pindex_wr); end
        if (u_if.pindex_wr_addr !== 3'd0 || u_if.pindex_wr_data !== 4'h0) begin
            bad++; $display("FAIL mid_rst_addr_data: got %h/%h required 0/0", u_if.pindex_wr_addr, u_if.pindex_wr_data);
        end
        rst = 1'b0;
        #1;
        bw = q_wa.size(); bd = n_done;
        repeat (6) @(negedge clk);
        #1;
        total += 2;
        if (q_wa.size() != bw || n_done != bd) begin
            bad++; $display("FAIL mid_post_rst_activity: got %0d writes %0d dones required 0 0", q_wa.size() - bw, n_done - bd);
        end
        if (u_if.in_rdy !== 1'b0) begin bad++; $display("FAIL mid_post_rst_idle: got in_rdy=%b required 0", u_if.in_rdy); end
        for (int i = 0; i < NBEAT; i++) pix[i] = 4'($urandom);
        build_model();
        bo = q_out.size(); bw = q_wa.size();
        begin_frame();
        drive_frame(20, 1'b0, 1'b0, -1, 1'b0);
        total++;
        if (q_wa.size() - bw != NW) begin bad++; $display("FAIL rerun_wr_count: got %0d required %0d", q_wa.size() - bw, NW); end
        for (int j = 0; j < NW; j++) begin
            total += 2;
            if (q_wa[bw+j] !== 3'(j)) begin bad++; $display("FAIL rerun_addr[%0d]: got %0d required %0d", j, q_wa[bw+j], j); end
            if (q_wd[bw+j] !== exp_wd[j]) begin bad++; $display("FAIL rerun_wdata[%0d]: got %b required %b", j, q_wd[bw+j], exp_wd[j]); end
        end
        for (int p = 0; p < NP; p++) begin
            total++;
            if (q_out[bo+p] !== exp_out[p]) begin bad++; $display("FAIL rerun_pool[%0d]: got %b required %b", p, q_out[bo+p], exp_out[p]); end
        end
    endtask

    task automatic test_ignored_inputs();
        int bo, bw, bd;
        for (int i = 0; i < NBEAT; i++) pix[i] = 4'($urandom);
        build_model();
        bo = q_out.size(); bw = q_wa.size(); bd = n_done;
        begin_frame();
        drive_frame(0, 1'b0, 1'b1, -1, 1'b0);
        total += 3;
        if (q_out.size() - bo != NP) begin bad++; $display("FAIL ign_out_count: got %0d required %0d", q_out.size() - bo, NP); end
        if (q_wa.size() - bw != NW) begin bad++; $display("FAIL ign_wr_count: got %0d required %0d", q_wa.size() - bw, NW); end
        if (n_done - bd != 1) begin bad++; $display("FAIL ign_done_count: got %0d required 1", n_done - bd); end
        for (int p = 0; p < NP; p++) begin
            total++;
            if (q_out[bo+p] !== exp_out[p]) begin bad++; $display("FAIL ign_pool[%0d]: got %b required %b", p, q_out[bo+p], exp_out[p]); end
        end
        for (int j = 0; j < NW; j++) begin
            total += 2;
            if (q_wa[bw+j] !== 3'(j)) begin bad++; $display("FAIL ign_addr[%0d]: got %0d required %0d", j, q_wa[bw+j], j); end
            if (q_wd[bw+j] !== exp_wd[j]) begin bad++; $display("FAIL ign_wdata[%0d]: got %b required %b", j, q_wd[bw+j], exp_wd[j]); end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_full_frame();
        test_back_to_back();
        test_reset_mid_write();
        test_ignored_inputs();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
